// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sample-tick baud generator, RX byte FIFO, overrun and level irq.
// Optional idle timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int DEPTH         = 16,
    parameter int DIV_W         = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [DIV_W-1:0]           divisor,
    output logic                       sample_tick,
    input  logic [7:0]                 phy_data,
    input  logic                       phy_valid,
    input  logic                       rd_req,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       overrun,
    input  logic                       ovr_clr,
    input  logic [$clog2(DEPTH):0]     irq_thresh,
    output logic                       irq,
    output logic                       timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [7:0]       mem [DEPTH];
    logic             push;
    logic             pop;
    logic             drop;
    logic [LW-1:0]    level_next;
    logic             overrun_next;
    logic             timeout_next;

    // A divisor of 0 behaves like 1: tick on every cycle.
    assign div_last = (divisor == '0) ? '0 : divisor - 1'b1;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    always_comb begin
        pop          = rd_req && !empty;
        push         = phy_valid && enable && (!full || pop);
        drop         = phy_valid && enable && !push;
        level_next   = level + LW'(push) - LW'(pop);
        overrun_next = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else if (!enable) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else if (div_cnt >= div_last) begin
            div_cnt     <= '0;
            sample_tick <= 1'b1;
        end else begin
            div_cnt     <= div_cnt + 1'b1;
            sample_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= phy_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= pop;
            level    <= level_next;
            overrun  <= overrun_next;
            irq      <= ((irq_thresh != '0) && (level_next >= irq_thresh))
                        || overrun_next || timeout_next;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    always_comb begin
        to_hit       = sample_tick && !timeout && !empty && !push && !pop
                       && (to_cnt == TW'(TIMEOUT_TICKS - 1));
        timeout_next = (pop || (level_next == '0)) ? 1'b0 : (to_hit || timeout);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (push || pop || empty || to_hit)
                to_cnt <= '0;
            else if (sample_tick && !timeout)
                to_cnt <= to_cnt + 1'b1;
            timeout <= timeout_next;
        end
    end
`else
    logic unused_timeout_ticks;

    assign unused_timeout_ticks = (TIMEOUT_TICKS != 0);
    assign timeout_next         = 1'b0;
    assign timeout              = 1'b0;
`endif
endmodule
